// File: rtl/sprite_pkg.sv
// Shared constants and types for the per-scanline sprite scheduler.
package sprite_pkg;
    localparam int         N_SPRITES   = 16;
    localparam int         N_SLOTS     = 4;
    localparam int         SPRITE_H    = 8;
    localparam logic [7:0] DISABLED_Y  = 8'hFF;
    localparam logic [5:0] STATUS_ADDR = 6'h20;

    // Scheduler phases: wait for a line, test one sprite, load one slot, finish.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/sprite_attr_ram.sv
// 32x8 sprite attribute table: even bytes hold X, odd bytes hold Y.
// One CPU read/write port plus combinational X/Y ports for the scanner.
module sprite_attr_ram
    import sprite_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_we,
    input  logic [4:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    input  logic [3:0] i_idx,
    output logic [7:0] o_x,
    output logic [7:0] o_y
);
    logic [7:0] r_mem [0:31];

    // Table storage; reset fills every byte with 0xFF so all sprites start disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= DISABLED_Y;
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Reads return the stored (pre-write) value, so a same-cycle write is not seen.
    assign o_rdata = r_mem[i_addr];
    assign o_x     = r_mem[{i_idx, 1'b0}];
    assign o_y     = r_mem[{i_idx, 1'b1}];
endmodule

// File: rtl/sprite_scheduler.sv
// Per-scanline sprite evaluator: on an hsync edge, scans the attribute table
// in index order and loads up to N_SLOTS visible sprites into the engine slots.
module sprite_scheduler #(
    parameter int N_SPRITES = sprite_pkg::N_SPRITES,
    parameter int N_SLOTS   = sprite_pkg::N_SLOTS,
    parameter int SPRITE_H  = sprite_pkg::SPRITE_H
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cs,
    input  logic               rw,
    input  logic [5:0]         addr,
    input  logic [7:0]         di,
    output logic [7:0]         dout,
    input  logic [6:0]         vpos,
    input  logic               hsync,
    input  logic               vsync,
    output logic               slot_we,
    output logic [1:0]         slot_idx,
    output logic [3:0]         slot_sprite,
    output logic [7:0]         slot_x,
    output logic [2:0]         slot_line,
    output logic [3:0]         slot_valid,
    output logic               busy,
    output logic               overflow,
    output sprite_pkg::state_t dbg_state
);
    import sprite_pkg::*;

    state_t     r_state, w_state_next;
    logic       r_hs_cur, r_hs_prev, r_vs_cur, r_vs_prev;
    logic [3:0] r_idx;
    logic [2:0] r_count;
    logic [7:0] r_dout;
    logic       r_slot_we, r_busy, r_overflow;
    logic [1:0] r_slot_idx;
    logic [3:0] r_slot_sprite, r_slot_valid;
    logic [7:0] r_slot_x;
    logic [2:0] r_slot_line;

    logic       w_hs_edge, w_vs_edge, w_ram_we, w_hit, w_idx_last, w_slots_full;
    logic       w_start, w_load, w_set_ovf, w_idx_inc, w_finish;
    logic [7:0] w_ram_rdata, w_x, w_y, w_target, w_d;

    assign w_ram_we = cs & rw & ~addr[5];

    sprite_attr_ram u_ram (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_we    (w_ram_we),
        .i_addr  (addr[4:0]),
        .i_wdata (di),
        .o_rdata (w_ram_rdata),
        .i_idx   (r_idx),
        .o_x     (w_x),
        .o_y     (w_y)
    );

    // Register the sync inputs once so edges are detected from prev/cur pairs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_cur  <= 1'b0;
            r_hs_prev <= 1'b0;
            r_vs_cur  <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_hs_cur  <= hsync;
            r_hs_prev <= r_hs_cur;
            r_vs_cur  <= vsync;
            r_vs_prev <= r_vs_cur;
        end
    end

    assign w_hs_edge    = r_hs_cur & ~r_hs_prev;
    assign w_vs_edge    = r_vs_cur & ~r_vs_prev;
    // Target is the next line; 127 becomes 128 because the top bit is zero-extended.
    assign w_target     = {1'b0, vpos} + 8'd1;
    assign w_d          = w_target - w_y;
    assign w_hit        = (w_y != DISABLED_Y) && (w_d < 8'(SPRITE_H));
    assign w_idx_last   = (r_idx == 4'(N_SPRITES - 1));
    assign w_slots_full = (r_count >= 3'(N_SLOTS));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state and datapath strobes; vsync overrides everything, hsync only counts in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_set_ovf    = 1'b0;
        w_idx_inc    = 1'b0;
        w_finish     = 1'b0;
        if (w_vs_edge) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_hs_edge) begin
                    w_start      = 1'b1;
                    w_state_next = EVAL;
                end
                EVAL: if (w_hit && !w_slots_full) begin
                    w_load       = 1'b1;
                    w_state_next = LOAD;
                end else if (w_hit) begin
                    w_set_ovf    = 1'b1;
                    w_state_next = DONE;
                end else if (w_idx_last) begin
                    w_state_next = DONE;
                end else begin
                    w_idx_inc    = 1'b1;
                end
                LOAD: if (w_idx_last) begin
                    w_state_next = DONE;
                end else begin
                    w_idx_inc    = 1'b1;
                    w_state_next = EVAL;
                end
                DONE: begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Scan datapath and slot outputs; slot registers are captured on the hit so
    // they and the one-cycle slot_we strobe are visible together during LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx         <= 4'd0;
            r_count       <= 3'd0;
            r_slot_we     <= 1'b0;
            r_slot_idx    <= 2'd0;
            r_slot_sprite <= 4'd0;
            r_slot_x      <= 8'd0;
            r_slot_line   <= 3'd0;
            r_slot_valid  <= 4'd0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_slot_we <= 1'b0;
            if (w_vs_edge) begin
                r_count      <= 3'd0;
                r_slot_valid <= 4'd0;
                r_busy       <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                if (w_start) begin
                    r_idx        <= 4'd0;
                    r_count      <= 3'd0;
                    r_slot_valid <= 4'd0;
                    r_overflow   <= 1'b0;
                    r_busy       <= 1'b1;
                end
                if (w_load) begin
                    r_slot_we                  <= 1'b1;
                    r_slot_idx                 <= r_count[1:0];
                    r_slot_sprite              <= r_idx;
                    r_slot_x                   <= w_x;
                    r_slot_line                <= w_d[2:0];
                    r_slot_valid[r_count[1:0]] <= 1'b1;
                    r_count                    <= r_count + 3'd1;
                end
                if (w_set_ovf) r_overflow <= 1'b1;
                if (w_idx_inc) r_idx      <= r_idx + 4'd1;
                if (w_finish)  r_busy     <= 1'b0;
            end
        end
    end

    // Registered CPU read port: table bytes, status word, zero elsewhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= 8'd0;
        end else if (cs && !rw) begin
            if (!addr[5])                 r_dout <= w_ram_rdata;
            else if (addr == STATUS_ADDR) r_dout <= {r_busy, r_overflow, 3'b000, r_count};
            else                          r_dout <= 8'd0;
        end
    end

    assign dout        = r_dout;
    assign slot_we     = r_slot_we;
    assign slot_idx    = r_slot_idx;
    assign slot_sprite = r_slot_sprite;
    assign slot_x      = r_slot_x;
    assign slot_line   = r_slot_line;
    assign slot_valid  = r_slot_valid;
    assign busy        = r_busy;
    assign overflow    = r_overflow;
    assign dbg_state   = r_state;
endmodule
